alu_resp_checker: RTL and testbench

//  On-chip response checker for the 64-bit ALU: the consuming end of the ALU

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_ref_model.sv | 65 ++++++
 rtl/alu_resp_checker.sv | 176 +++++++++++++++++
 tb/tb_alu_resp_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU response checker: control codes, status
// encodings and the {c,v,n,z} flag bit positions.
package alu_pkg;

  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSrl  = 4'b0011;
  localparam logic [3:0] CtrlXor  = 4'b0100;
  localparam logic [3:0] CtrlSll  = 4'b0101;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlSra  = 4'b0111;
  localparam logic [3:0] CtrlSlt  = 4'b1000;
  localparam logic [3:0] CtrlSltu = 4'b1001;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StPassing = 2'b01,
    StFailed  = 2'b10
  } status_e;

  // Flag vector layout is {c,v,n,z}.
  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagV = 2;
  localparam int unsigned FlagC = 3;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: recomputes result and {c,v,n,z} for a beat.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       control_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o,
  output logic             defined_o
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [ShW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             ovf;

  assign shamt = b_i[ShW-1:0];
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = a_i - b_i;

  // Decode the control code into the golden result and carry/overflow.
  always_comb begin
    result_o  = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    defined_o = 1'b1;
    case (control_i)
      CtrlAnd: result_o = a_i & b_i;
      CtrlOr:  result_o = a_i | b_i;
      CtrlXor: result_o = a_i ^ b_i;
      CtrlAdd: begin
        result_o = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        ovf      = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      CtrlSub: begin
        result_o = diff;
        carry    = a_i < b_i;  // borrow
        ovf      = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      CtrlSll:  result_o = a_i << shamt;
      CtrlSrl:  result_o = a_i >> shamt;
      CtrlSra:  result_o = $signed(a_i) >>> shamt;
      CtrlSlt:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      CtrlSltu: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default:  defined_o = 1'b0;
    endcase
  end

  // Assemble {c,v,n,z}.
  always_comb begin
    flags_o        = '0;
    flags_o[FlagC] = carry;
    flags_o[FlagV] = ovf;
    flags_o[FlagN] = result_o[WIDTH-1];
    flags_o[FlagZ] = (result_o == '0);
  end

endmodule

// File: rtl/alu_resp_checker.sv
// ALU response checker: S1 registers the beat with its golden response,
// S2 compares and updates saturating counters, status and first-fail capture.
module alu_resp_checker
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned CNT_W      = 16,
  parameter bit          CHECK_FLGS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic [3:0]       in_control_i,
  input  logic [WIDTH-1:0] in_result_i,
  input  logic [3:0]       in_flags_i,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] skip_cnt_o,
  output logic [1:0]       status_o,
  output logic [CNT_W-1:0] fail_idx_o,
  output logic [3:0]       fail_ctrl_o,
  output logic [WIDTH-1:0] fail_got_o,
  output logic [WIDTH-1:0] fail_exp_o,
  output logic [7:0]       fail_flags_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] ref_result;
  logic [3:0]       ref_flags;
  logic             ref_defined;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i       (in_a_i),
    .b_i       (in_b_i),
    .control_i (in_control_i),
    .result_o  (ref_result),
    .flags_o   (ref_flags),
    .defined_o (ref_defined)
  );

  // S1 state
  logic             s1_valid_q;
  logic             s1_defined_q;
  logic [3:0]       s1_ctrl_q;
  logic [WIDTH-1:0] s1_got_q, s1_exp_q;
  logic [3:0]       s1_got_flags_q, s1_exp_flags_q;

  // S2 state
  status_e          status_q, status_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, skip_q, skip_d, total_q, total_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [3:0]       fctrl_q, fctrl_d;
  logic [WIDTH-1:0] fgot_q, fgot_d, fexp_q, fexp_d;
  logic [7:0]       fflags_q, fflags_d;

  logic mismatch;
  assign mismatch = (s1_got_q != s1_exp_q) ||
                    (CHECK_FLGS && (s1_got_flags_q != s1_exp_flags_q));

  // S1: register the beat alongside its golden response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_defined_q   <= 1'b0;
      s1_ctrl_q      <= '0;
      s1_got_q       <= '0;
      s1_exp_q       <= '0;
      s1_got_flags_q <= '0;
      s1_exp_flags_q <= '0;
    end else if (clear_i) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_defined_q   <= ref_defined;
        s1_ctrl_q      <= in_control_i;
        s1_got_q       <= in_result_i;
        s1_exp_q       <= ref_result;
        s1_got_flags_q <= in_flags_i;
        s1_exp_flags_q <= ref_flags;
      end
    end
  end

  // S2 next state: compare, count, walk the status FSM, capture first fail.
  always_comb begin
    status_d = status_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    skip_d   = skip_q;
    total_d  = total_q;
    fidx_d   = fidx_q;
    fctrl_d  = fctrl_q;
    fgot_d   = fgot_q;
    fexp_d   = fexp_q;
    fflags_d = fflags_q;
    if (clear_i) begin
      status_d = StIdle;
      pass_d   = '0;
      fail_d   = '0;
      skip_d   = '0;
      total_d  = '0;
      fidx_d   = '0;
      fctrl_d  = '0;
      fgot_d   = '0;
      fexp_d   = '0;
      fflags_d = '0;
    end else if (s1_valid_q && !s1_defined_q) begin
      skip_d  = sat_inc(skip_q);
      total_d = sat_inc(total_q);
    end else if (s1_valid_q) begin
      total_d = sat_inc(total_q);
      if (mismatch) fail_d = sat_inc(fail_q);
      else          pass_d = sat_inc(pass_q);
      case (status_q)
        StIdle, StPassing: begin
          if (mismatch) begin
            status_d = StFailed;
            fidx_d   = total_q;
            fctrl_d  = s1_ctrl_q;
            fgot_d   = s1_got_q;
            fexp_d   = s1_exp_q;
            fflags_d = {s1_got_flags_q, s1_exp_flags_q};
          end else begin
            status_d = StPassing;
          end
        end
        default: status_d = StFailed;
      endcase
    end
  end

  // S2 state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= StIdle;
      pass_q   <= '0;
      fail_q   <= '0;
      skip_q   <= '0;
      total_q  <= '0;
      fidx_q   <= '0;
      fctrl_q  <= '0;
      fgot_q   <= '0;
      fexp_q   <= '0;
      fflags_q <= '0;
    end else begin
      status_q <= status_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      skip_q   <= skip_d;
      total_q  <= total_d;
      fidx_q   <= fidx_d;
      fctrl_q  <= fctrl_d;
      fgot_q   <= fgot_d;
      fexp_q   <= fexp_d;
      fflags_q <= fflags_d;
    end
  end

  assign pass_cnt_o   = pass_q;
  assign fail_cnt_o   = fail_q;
  assign skip_cnt_o   = skip_q;
  assign status_o     = status_q;
  assign fail_idx_o   = fidx_q;
  assign fail_ctrl_o  = fctrl_q;
  assign fail_got_o   = fgot_q;
  assign fail_exp_o   = fexp_q;
  assign fail_flags_o = fflags_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Self-checking bench for alu_resp_checker: table of single beats, then
// directed multi-cycle sequences (latency, capture, clear, saturation, reset).
module tb_alu_resp_checker;
  import alu_pkg::*;

  localparam int W = 64;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, in_result = '0;
  logic [3:0]   in_control = '0, in_flags = '0;

  logic [15:0]  pass_cnt, fail_cnt, skip_cnt, fail_idx;
  logic [1:0]   status;
  logic [3:0]   fail_ctrl;
  logic [W-1:0] fail_got, fail_exp;
  logic [7:0]   fail_flags;

  logic [3:0]   p4, f4, s4, fi4;
  logic [1:0]   st4;
  logic [3:0]   fc4;
  logic [W-1:0] fg4, fe4;
  logic [7:0]   ff4;

  alu_resp_checker #(.WIDTH(W), .CNT_W(16), .CHECK_FLGS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_a_i(in_a), .in_b_i(in_b), .in_control_i(in_control),
    .in_result_i(in_result), .in_flags_i(in_flags),
    .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt), .skip_cnt_o(skip_cnt),
    .status_o(status), .fail_idx_o(fail_idx), .fail_ctrl_o(fail_ctrl),
    .fail_got_o(fail_got), .fail_exp_o(fail_exp), .fail_flags_o(fail_flags)
  );

  alu_resp_checker #(.WIDTH(W), .CNT_W(4), .CHECK_FLGS(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_a_i(in_a), .in_b_i(in_b), .in_control_i(in_control),
    .in_result_i(in_result), .in_flags_i(in_flags),
    .pass_cnt_o(p4), .fail_cnt_o(f4), .skip_cnt_o(s4),
    .status_o(st4), .fail_idx_o(fi4), .fail_ctrl_o(fc4),
    .fail_got_o(fg4), .fail_exp_o(fe4), .fail_flags_o(ff4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c,
                          input logic [63:0] r, input logic [3:0] f);
    in_a = a; in_b = b; in_control = c; in_result = r; in_flags = f; in_valid = 1'b1;
  endtask

  // One isolated beat; returns once its effect is visible on the counters.
  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c,
                      input logic [63:0] r, input logic [3:0] f);
    set_beat(a, b, c, r, f);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctrl;
    logic [63:0] got;
    logic [3:0]  flg;
    int          kind;  // 0 pass, 1 fail, 2 skip
  } vec_t;

  vec_t vecs[12];

  initial begin
    int ep, ef, es;
    logic [1:0] est;

    vecs[0]  = '{64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, CtrlAnd,
                 64'h000F_000F_000F_000F, 4'b0000, 0};
    vecs[1]  = '{MIN, 64'd1, CtrlOr, 64'h8000_0000_0000_0001, 4'b0010, 0};
    vecs[2]  = '{64'h1234, 64'h1234, CtrlXor, 64'd0, 4'b0001, 0};
    vecs[3]  = '{64'd1, 64'h41, CtrlSll, 64'd2, 4'b0000, 0};
    vecs[4]  = '{MIN, 64'd4, CtrlSrl, 64'h0800_0000_0000_0000, 4'b0000, 0};
    vecs[5]  = '{64'd3, 64'd5, CtrlSub, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010, 0};
    vecs[6]  = '{MIN, 64'd1, CtrlSub, MAX, 4'b0100, 0};
    vecs[7]  = '{ONES, 64'd1, CtrlSlt, 64'd1, 4'b0000, 0};
    vecs[8]  = '{ONES, 64'd1, CtrlSltu, 64'd0, 4'b0001, 0};
    vecs[9]  = '{ONES, 64'd1, CtrlAdd, 64'd0, 4'b1001, 0};
    vecs[10] = '{64'd5, 64'd3, CtrlAdd, 64'd8, 4'b0001, 1};
    vecs[11] = '{64'd5, 64'd3, 4'b1010, 64'd0, 4'b0000, 2};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_skip", skip_cnt, 0);
    check("rst_status", status, 0);
    check("rst_fail_idx", fail_idx, 0);
    check("rst_fail_got", fail_got, 0);
    check("rst_fail_flags", fail_flags, 0);
    rst_n = 1'b1;
    tick();

    // Table of single beats with a small counter/status model
    ep = 0; ef = 0; es = 0; est = 2'b00;
    for (int i = 0; i < 12; i++) begin
      beat(vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].got, vecs[i].flg);
      if (vecs[i].kind == 0) begin
        ep++;
        if (est == 2'b00) est = 2'b01;
      end else if (vecs[i].kind == 1) begin
        ef++;
        est = 2'b10;
      end else begin
        es++;
      end
      check($sformatf("vec%0d_pass", i), pass_cnt, ep);
      check($sformatf("vec%0d_fail", i), fail_cnt, ef);
      check($sformatf("vec%0d_skip", i), skip_cnt, es);
      check($sformatf("vec%0d_status", i), status, est);
    end
    check("vec_fail_idx", fail_idx, 10);
    check("vec_fail_ctrl", fail_ctrl, CtrlAdd);
    check("vec_fail_got", fail_got, 8);
    check("vec_fail_exp", fail_exp, 8);
    check("vec_fail_flags", fail_flags, 8'b0001_0000);

    // 1: back-to-back ADD/SUB, 2-cycle latency
    do_clear();
    check("clr_status", status, 0);
    set_beat(64'd5, 64'd3, CtrlAdd, 64'd8, 4'b0000);
    tick();
    check("t1_latency", pass_cnt, 0);
    set_beat(64'd8, 64'd3, CtrlSub, 64'd5, 4'b0000);
    tick();
    in_valid = 1'b0;
    check("t1_first", pass_cnt, 1);
    tick();
    check("t1_pass", pass_cnt, 2);
    check("t1_status", status, 2'b01);

    // 2: overflow pass, then MIN+MIN with wrong flags
    do_clear();
    beat(MAX, 64'd1, CtrlAdd, MIN, 4'b0110);
    check("t2_pass", pass_cnt, 1);
    beat(MIN, MIN, CtrlAdd, 64'd0, 4'b0000);
    check("t2_fail", fail_cnt, 1);
    check("t2_status", status, 2'b10);
    check("t2_fail_idx", fail_idx, 1);
    check("t2_fail_ctrl", fail_ctrl, CtrlAdd);
    check("t2_fail_got", fail_got, 0);
    check("t2_fail_exp", fail_exp, 0);
    check("t2_fail_flags", fail_flags, 8'b0000_1101);

    // 3: later fail leaves the capture alone
    beat(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, CtrlAnd, 64'd1, 4'b0000);
    check("t3_fail", fail_cnt, 2);
    check("t3_fail_idx", fail_idx, 1);
    check("t3_fail_got", fail_got, 0);
    check("t3_fail_flags", fail_flags, 8'b0000_1101);

    // 4: skip then SRA pass; FAILED stays
    beat(64'd1, 64'd1, 4'b1111, 64'd0, 4'b0000);
    check("t4_skip", skip_cnt, 1);
    check("t4_status_skip", status, 2'b10);
    beat(MIN, 64'd63, CtrlSra, ONES, 4'b0010);
    check("t4_sra_pass", pass_cnt, 2);
    check("t4_status", status, 2'b10);
    check("t4_fail_idx", fail_idx, 1);

    // 5: clear together with a beat, and with a beat sitting in S1
    set_beat(64'd5, 64'd3, CtrlAdd, 64'd8, 4'b0000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check("t5a_pass", pass_cnt, 0);
    check("t5a_fail", fail_cnt, 0);
    check("t5a_skip", skip_cnt, 0);
    check("t5a_status", status, 0);
    check("t5a_fail_flags", fail_flags, 0);
    beat(64'd5, 64'd3, CtrlAdd, 64'd8, 4'b0000);
    check("t5b_pre", pass_cnt, 1);
    set_beat(64'd5, 64'd3, CtrlAdd, 64'd8, 4'b0000);
    tick();
    in_valid = 1'b0;
    do_clear();
    tick();
    tick();
    check("t5b_pass", pass_cnt, 0);
    check("t5b_status", status, 0);

    // 6: saturation on the 4-bit instance, then async reset mid-burst
    set_beat(64'd5, 64'd3, CtrlAdd, 64'd8, 4'b0000);
    repeat (20) tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t6_sat4", p4, 15);
    check("t6_pass16", pass_cnt, 20);
    check("t6_status4", st4, 2'b01);
    set_beat(64'd5, 64'd3, CtrlAdd, 64'd8, 4'b0000);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_pass", pass_cnt, 0);
    check("t6_rst_status", status, 0);
    check("t6_rst_pass4", p4, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_no_late", pass_cnt, 0);
    check("t6_no_late_status", status, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
